mantissa_aligner: RTL and testbench

//  Right-shift alignment stage: inverse of the left-shift normaliser. Raises a 53-bit mantissa's exponent
//  to a target exponent by shifting right. Keeps guard/round/sticky bits for later rounding.

---
 rtl/mantissa_aligner.sv | 167 ++++++++++++++++
 tb/tb_mantissa_aligner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mantissa_aligner.sv
// Right-shift mantissa alignment stage ahead of the FP adder.
// Shifts a 53-bit mantissa right by (Target_Exp - Input_Exp) positions, at
// most SHIFT_STEP positions per cycle. It keeps the guard, round and sticky
// bits for later rounding. Valid/ready handshake on both sides, one
// operation in flight.
// Build option: define ALIGNER_STICKY_EN to accumulate the sticky bit.
// When it is left undefined, Sticky_Bit is tied 0 (truncating alignment).
module mantissa_aligner #(
   parameter int unsigned SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [52:0] Input_Mantissa,
   input  logic [10:0] Input_Exp,
   input  logic [10:0] Target_Exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [52:0] Output_Mantissa,
   output logic [10:0] Output_Exp,
   output logic        Guard_Bit,
   output logic        Round_Bit,
   output logic        Sticky_Bit,
   output logic        align_err
);

   localparam int unsigned MANT_W = 53;
   localparam int unsigned EXP_W  = 11;
   localparam int unsigned WORK_W = MANT_W + 2;
   localparam int unsigned DIFF_W = EXP_W + 1;
   localparam int unsigned REM_W  = 6;

   localparam logic [REM_W-1:0]  STEP_R  = REM_W'(SHIFT_STEP);
   localparam logic [REM_W-1:0]  REM_MAX = REM_W'(WORK_W);
   localparam logic [DIFF_W-1:0] DIFF_MAX = DIFF_W'(WORK_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   logic [WORK_W-1:0]   w;
   logic                s;
   logic [REM_W-1:0]    rem;

   logic [DIFF_W-1:0]   diff;
   logic                diff_neg;
   logic [REM_W-1:0]    rem_init;

   logic [REM_W-1:0]    step_k;
   logic [REM_W-1:0]    rem_next;
   logic [WORK_W-1:0]   w_shift;
   logic                s_next;

   // Exponent difference for the operand being offered, clamped to the work width
   always_comb begin
      diff     = {1'b0, Target_Exp} - {1'b0, Input_Exp};
      diff_neg = diff[DIFF_W-1];
      rem_init = '0;
      if (!diff_neg) begin
         if (diff > DIFF_MAX) begin
            rem_init = REM_MAX;
         end else begin
            rem_init = diff[REM_W-1:0];
         end
      end
   end

   // One shift step: move by min(rem, SHIFT_STEP) and fold the lost bits into sticky
`ifdef ALIGNER_STICKY_EN
   logic [WORK_W-1:0]   lost_bits;

   always_comb begin
      step_k    = (rem < STEP_R) ? rem : STEP_R;
      rem_next  = rem - step_k;
      w_shift   = w >> step_k;
      lost_bits = w & ~({WORK_W{1'b1}} << step_k);
      s_next    = s | (|lost_bits);
   end
`else
   always_comb begin
      step_k   = (rem < STEP_R) ? rem : STEP_R;
      rem_next = rem - step_k;
      w_shift  = w >> step_k;
      s_next   = 1'b0;
   end
`endif

   // Control FSM with working registers and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         w               <= '0;
         s               <= 1'b0;
         rem             <= '0;
         in_ready        <= 1'b1;
         out_valid       <= 1'b0;
         Output_Mantissa <= '0;
         Output_Exp      <= '0;
         Guard_Bit       <= 1'b0;
         Round_Bit       <= 1'b0;
         Sticky_Bit      <= 1'b0;
         align_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  w        <= {Input_Mantissa, 2'b00};
                  s        <= 1'b0;
                  rem      <= rem_init;
                  in_ready <= 1'b0;
                  if (diff_neg) begin
                     Output_Exp <= Input_Exp;
                     align_err  <= 1'b1;
                  end else begin
                     Output_Exp <= Target_Exp;
                     align_err  <= 1'b0;
                  end
                  if (rem_init != '0) begin
                     state <= SHIFT;
                  end else begin
                     // No shift needed: result is the operand itself
                     state           <= DONE;
                     out_valid       <= 1'b1;
                     Output_Mantissa <= Input_Mantissa;
                     Guard_Bit       <= 1'b0;
                     Round_Bit       <= 1'b0;
                     Sticky_Bit      <= 1'b0;
                  end
               end
            end

            SHIFT: begin
               w   <= w_shift;
               s   <= s_next;
               rem <= rem_next;
               if (rem_next == '0) begin
                  state           <= DONE;
                  out_valid       <= 1'b1;
                  Output_Mantissa <= w_shift[WORK_W-1:2];
                  Guard_Bit       <= w_shift[1];
                  Round_Bit       <= w_shift[0];
                  Sticky_Bit      <= s_next;
               end
            end

            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mantissa_aligner.sv
// Directed testbench for mantissa_aligner (SHIFT_STEP = 8).
module tb_mantissa_aligner;

`ifdef ALIGNER_STICKY_EN
   localparam bit STICKY_ON = 1'b1;
`else
   localparam bit STICKY_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [52:0] Input_Mantissa;
   logic [10:0] Input_Exp;
   logic [10:0] Target_Exp;
   logic        out_valid;
   logic        out_ready;
   logic [52:0] Output_Mantissa;
   logic [10:0] Output_Exp;
   logic        Guard_Bit;
   logic        Round_Bit;
   logic        Sticky_Bit;
   logic        align_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mantissa_aligner #(.SHIFT_STEP(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .Input_Mantissa  (Input_Mantissa),
      .Input_Exp       (Input_Exp),
      .Target_Exp      (Target_Exp),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .Output_Mantissa (Output_Mantissa),
      .Output_Exp      (Output_Exp),
      .Guard_Bit       (Guard_Bit),
      .Round_Bit       (Round_Bit),
      .Sticky_Bit      (Sticky_Bit),
      .align_err       (align_err)
   );

   // Single comparison point: count, and report any mismatch
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [52:0] m, input logic [10:0] e,
                                input logic g, input logic r, input logic s, input logic err);
      check_val({tag, ".mant"},   64'(Output_Mantissa), 64'(m));
      check_val({tag, ".exp"},    64'(Output_Exp),      64'(e));
      check_val({tag, ".guard"},  64'(Guard_Bit),       64'(g));
      check_val({tag, ".round"},  64'(Round_Bit),       64'(r));
      check_val({tag, ".sticky"}, 64'(Sticky_Bit),      64'(s));
      check_val({tag, ".err"},    64'(align_err),       64'(err));
   endtask

   // Present one operand, measure latency, check result, optionally stall the consumer
   task automatic run_op(input string tag, input logic [52:0] m, input logic [10:0] e,
                         input logic [10:0] t, input int exp_lat,
                         input logic [52:0] xm, input logic [10:0] xe,
                         input logic xg, input logic xr, input logic xs, input logic xerr,
                         input int hold);
      int lat;
      @(negedge clk);
      check_val({tag, ".in_ready"}, 64'(in_ready), 64'(1));
      out_ready      = (hold == 0);
      Input_Mantissa = m;
      Input_Exp      = e;
      Target_Exp     = t;
      in_valid       = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check_outputs(tag, xm, xe, xg, xr, xs, xerr);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_val({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
         check_val({tag, ".hold_ready"}, 64'(in_ready),  64'(0));
         check_outputs({tag, ".hold"}, xm, xe, xg, xr, xs, xerr);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val({tag, ".post_valid"}, 64'(out_valid), 64'(0));
      check_val({tag, ".post_ready"}, 64'(in_ready),  64'(1));
   endtask

   initial begin
      int seen;
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      out_ready      = 1'b1;
      Input_Mantissa = '0;
      Input_Exp      = '0;
      Target_Exp     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst.in_ready",  64'(in_ready),  64'(1));
      check_val("rst.out_valid", 64'(out_valid), 64'(0));
      check_outputs("rst", 53'h0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Equal exponents: pass-through
      run_op("eq", 53'h10_0000_0000_0000, 11'd1023, 11'd1023, 1,
             53'h10_0000_0000_0000, 11'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      // Shift by 3: G, R and sticky all set
      run_op("sh3", 53'h1F_FFFF_FFFF_FFFF, 11'd1000, 11'd1003, 2,
             53'h03_FFFF_FFFF_FFFF, 11'd1003, 1'b1, 1'b1, STICKY_ON, 1'b0, 0);
      // Maximum gap clamps to 55
      run_op("clamp", 53'h10_0000_0000_0001, 11'd0, 11'd2047, 8,
             53'h0, 11'd2047, 1'b0, 1'b0, STICKY_ON, 1'b0, 0);
      // Target below input exponent
      run_op("err", 53'h15_5555_5555_5555, 11'd1030, 11'd1020, 1,
             53'h15_5555_5555_5555, 11'd1030, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      // Exactly one full step
      run_op("sh8", 53'h00_0000_0000_00FF, 11'd100, 11'd108, 2,
             53'h0, 11'd108, 1'b1, 1'b1, STICKY_ON, 1'b0, 0);
      // One past a full step: bit lands in sticky only
      run_op("sh9", 53'h00_0000_0000_0001, 11'd50, 11'd59, 3,
             53'h0, 11'd59, 1'b0, 1'b0, STICKY_ON, 1'b0, 0);
      // Hidden bit lands in guard / round
      run_op("sh53", 53'h10_0000_0000_0000, 11'd10, 11'd63, 8,
             53'h0, 11'd63, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      run_op("sh54", 53'h10_0000_0000_0000, 11'd10, 11'd64, 8,
             53'h0, 11'd64, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      // Zero mantissa on the shifting path
      run_op("zero", 53'h0, 11'd5, 11'd20, 3,
             53'h0, 11'd20, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      // Back-pressure for 5 cycles, then the next operand immediately after
      run_op("bp", 53'h10_0000_0000_0000, 11'd1023, 11'd1023, 1,
             53'h10_0000_0000_0000, 11'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 5);
      run_op("bp_next", 53'h1F_FFFF_FFFF_FFFF, 11'd1000, 11'd1003, 2,
             53'h03_FFFF_FFFF_FFFF, 11'd1003, 1'b1, 1'b1, STICKY_ON, 1'b0, 0);
      run_op("err2", 53'h00_0000_0000_0003, 11'd9, 11'd8, 1,
             53'h00_0000_0000_0003, 11'd9, 1'b0, 1'b0, 1'b0, 1'b1, 0);

      // Reset in the middle of a long shift
      @(negedge clk);
      Input_Mantissa = 53'h10_0000_0000_0001;
      Input_Exp      = 11'd0;
      Target_Exp     = 11'd2047;
      in_valid       = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("mid_rst.in_ready",  64'(in_ready),  64'(1));
      check_val("mid_rst.out_valid", 64'(out_valid), 64'(0));
      check_outputs("mid_rst", 53'h0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check_val("mid_rst.stale_valid", 64'(seen), 64'(0));

      // Operation after reset proceeds normally
      run_op("after_rst", 53'h1F_FFFF_FFFF_FFFF, 11'd1000, 11'd1003, 2,
             53'h03_FFFF_FFFF_FFFF, 11'd1003, 1'b1, 1'b1, STICKY_ON, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
